// File: rtl/e_mdu_pkg.sv
// Shared types for the E-stage multiply/divide unit: mdu_op encodings and FSM states.
// Defining MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU encodings.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
`ifdef MDU_MADD_EN
    ,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
`endif
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/e_mdu_if.sv
// E-stage to MDU signal bundle; master is the pipeline side, slave is the MDU.
// Handshake: the MDU accepts a start at a rising edge only when start=1, busy=0 and req=0.
interface e_mdu_if;
  import e_mdu_pkg::*;

  logic        req;
  logic [3:0]  mdu_op;
  logic        start;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] out;
  mdu_state_e  state;

  modport master (
    output req, mdu_op, start, rs, rt,
    input  busy, out, state
  );

  modport slave (
    input  req, mdu_op, start, rs, rt,
    output busy, out, state
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO; multi-cycle MULT/DIV with a registered busy.
// Defining MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (accumulate into {HI,LO}).
module e_mdu
  import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic    clk,
    input logic    reset,
    e_mdu_if.slave mdu
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [31:0]      hi, lo, pending_hi, pending_lo;
    logic             pending_wr;
    logic             busy_q;
    logic [CNT_W-1:0] cnt;
    mdu_state_e       state;

    logic [63:0]      prod_s, prod_u;
    logic [31:0]      divisor, quot_s, rem_s, quot_u, rem_u;
    logic [31:0]      res_hi, res_lo;
    logic             res_wr, start_op, accept;
    logic [CNT_W-1:0] res_cnt;

    // Divisor is forced to 1 on zero so the datapath never divides by zero;
    // the result is discarded at commit in that case.
    always_comb begin
        prod_s  = $signed({{32{mdu.rs[31]}}, mdu.rs}) * $signed({{32{mdu.rt[31]}}, mdu.rt});
        prod_u  = {32'd0, mdu.rs} * {32'd0, mdu.rt};
        divisor = (mdu.rt == 32'd0) ? 32'd1 : mdu.rt;
        quot_s  = $signed(mdu.rs) / $signed(divisor);
        rem_s   = $signed(mdu.rs) % $signed(divisor);
        quot_u  = mdu.rs / divisor;
        rem_u   = mdu.rs % divisor;
    end

    always_comb begin
        res_hi   = hi;
        res_lo   = lo;
        res_wr   = 1'b0;
        res_cnt  = CNT_W'(MULT_CYCLES);
        start_op = 1'b0;
        case (mdu.mdu_op)
            MDU_MULT: begin
                start_op         = 1'b1;
                res_wr           = 1'b1;
                {res_hi, res_lo} = prod_s;
            end
            MDU_MULTU: begin
                start_op         = 1'b1;
                res_wr           = 1'b1;
                {res_hi, res_lo} = prod_u;
            end
            MDU_DIV: begin
                start_op = 1'b1;
                res_wr   = (mdu.rt != 32'd0);
                res_hi   = rem_s;
                res_lo   = quot_s;
                res_cnt  = CNT_W'(DIV_CYCLES);
            end
            MDU_DIVU: begin
                start_op = 1'b1;
                res_wr   = (mdu.rt != 32'd0);
                res_hi   = rem_u;
                res_lo   = quot_u;
                res_cnt  = CNT_W'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            MDU_MADD: begin
                start_op         = 1'b1;
                res_wr           = 1'b1;
                {res_hi, res_lo} = {hi, lo} + prod_s;
            end
            MDU_MADDU: begin
                start_op         = 1'b1;
                res_wr           = 1'b1;
                {res_hi, res_lo} = {hi, lo} + prod_u;
            end
            MDU_MSUB: begin
                start_op         = 1'b1;
                res_wr           = 1'b1;
                {res_hi, res_lo} = {hi, lo} - prod_s;
            end
            MDU_MSUBU: begin
                start_op         = 1'b1;
                res_wr           = 1'b1;
                {res_hi, res_lo} = {hi, lo} - prod_u;
            end
`endif
            default: ;
        endcase
        accept = mdu.start && start_op && !busy_q && !mdu.req;
    end

    // Result is captured at acceptance and only reaches HI/LO on the cnt 1->0 edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi         <= 32'd0;
            lo         <= 32'd0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            pending_wr <= 1'b0;
            cnt        <= '0;
            busy_q     <= 1'b0;
            state      <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        pending_hi <= res_hi;
                        pending_lo <= res_lo;
                        pending_wr <= res_wr;
                        cnt        <= res_cnt;
                        busy_q     <= 1'b1;
                        state      <= ST_RUN;
                    end else if (!mdu.req && mdu.mdu_op == MDU_MTHI) begin
                        hi <= mdu.rs;
                    end else if (!mdu.req && mdu.mdu_op == MDU_MTLO) begin
                        lo <= mdu.rs;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        if (pending_wr) begin
                            hi <= pending_hi;
                            lo <= pending_lo;
                        end
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (mdu.mdu_op)
            MDU_MFHI: mdu.out = hi;
            MDU_MFLO: mdu.out = lo;
            default:  mdu.out = 32'd0;
        endcase
    end

    assign mdu.busy  = busy_q;
    assign mdu.state = state;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus randomized ops against a
// 64-bit arithmetic reference model of HI/LO.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int N_MUL = 5;
  localparam int N_DIV = 10;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_mdu_if mdu ();

  e_mdu #(.MULT_CYCLES(N_MUL), .DIV_CYCLES(N_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;
  logic [31:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    mdu.req    = 1'b0;
    mdu.mdu_op = MDU_NONE;
    mdu.start  = 1'b0;
    mdu.rs     = 32'd0;
    mdu.rt     = 32'd0;
  endtask

  // Present one op for exactly one rising edge; returns at the negedge after it.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic rq);
    @(negedge clk);
    mdu.mdu_op = op;
    mdu.rs     = a;
    mdu.rt     = b;
    mdu.start  = st;
    mdu.req    = rq;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (mdu.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    mdu.mdu_op = MDU_MFHI;
    #1 h = mdu.out;
    mdu.mdu_op = MDU_MFLO;
    #1 l = mdu.out;
    mdu.mdu_op = MDU_NONE;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic [31:0] h, output logic [31:0] l);
    issue(op, a, b, 1'b1, 1'b0);
    count_busy(n);
    read_hilo(h, l);
  endtask

  // ---------------- reference model ----------------
  // Returns {write, hi, lo} from architectural definitions of each op.
  function automatic logic [64:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ma, mb, q, r;
    longint unsigned ua, ub, up;
    logic [63:0] p;
    ref_result = {1'b0, m_hi, m_lo};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MDU_MULT: begin
        p = sa * sb;
        ref_result = {1'b1, p};
      end
      MDU_MULTU: begin
        up = ua * ub;
        ref_result = {1'b1, up};
      end
      MDU_DIV: if (b != 32'd0) begin
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        q = ma / mb;
        r = ma % mb;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        ref_result = {1'b1, r[31:0], q[31:0]};
      end
      MDU_DIVU: if (b != 32'd0) begin
        ref_result = {1'b1, a % b, a / b};
      end
      default: ;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] h, l;
    drive_idle();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    checks++;
    if (mdu.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mdu.busy); end
    checks++;
    if (mdu.state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", mdu.state, ST_IDLE); end
    checks++;
    if (mdu.out !== 32'd0) begin failures++; $display("FAIL reset_out_none got=%h exp=0", mdu.out); end
    read_hilo(h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'd0) begin failures++; $display("FAIL reset_hilo got=%h_%h exp=0_0", h, l); end
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_mult();
    int n;
    logic [31:0] h, l;
    run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, n, h, l);
    checks++;
    if (n !== N_MUL) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", n, N_MUL); end
    checks++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFA) begin
      failures++; $display("FAIL mult_result got=%h_%h exp=ffffffff_fffffffa", h, l);
    end
    run_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, n, h, l);
    checks++;
    if (n !== N_MUL) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=%0d", n, N_MUL); end
    checks++;
    if (h !== 32'h2 || l !== 32'hFFFF_FFFA) begin
      failures++; $display("FAIL multu_result got=%h_%h exp=00000002_fffffffa", h, l);
    end
    m_hi = 32'h2;
    m_lo = 32'hFFFF_FFFA;
  endtask

  task automatic test_div();
    int n;
    logic [31:0] h, l;
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n, h, l);
    checks++;
    if (n !== N_DIV) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=%0d", n, N_DIV); end
    checks++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
      failures++; $display("FAIL div_result got=%h_%h exp=ffffffff_fffffffd", h, l);
    end
    run_op(MDU_DIVU, 32'd7, 32'd0, n, h, l);
    checks++;
    if (n !== N_DIV) begin failures++; $display("FAIL divu_zero_busy got=%0d exp=%0d", n, N_DIV); end
    checks++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
      failures++; $display("FAIL divu_zero_unchanged got=%h_%h exp=ffffffff_fffffffd", h, l);
    end
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFFD;
  endtask

  task automatic test_mt();
    logic [31:0] h, l;
    issue(MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    checks++;
    if (mdu.busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", mdu.busy); end
    read_hilo(h, l);
    checks++;
    if (h !== 32'h1234_5678 || l !== m_lo) begin
      failures++; $display("FAIL mthi_mfhi got=%h_%h exp=12345678_%h", h, l, m_lo);
    end
    m_hi = 32'h1234_5678;
    issue(MDU_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
    read_hilo(h, l);
    checks++;
    if (h !== m_hi || l !== m_lo) begin
      failures++; $display("FAIL mtlo_req_blocked got=%h_%h exp=%h_%h", h, l, m_hi, m_lo);
    end
  endtask

  task automatic test_req();
    int n;
    logic [31:0] h, l;
    issue(MDU_MULT, 32'd5, 32'd6, 1'b1, 1'b1);
    checks++;
    if (mdu.busy !== 1'b0) begin failures++; $display("FAIL req_start_busy got=%b exp=0", mdu.busy); end
    repeat (N_MUL + 2) @(negedge clk);
    read_hilo(h, l);
    checks++;
    if (h !== m_hi || l !== m_lo) begin
      failures++; $display("FAIL req_start_hilo got=%h_%h exp=%h_%h", h, l, m_hi, m_lo);
    end
    // req raised in the third busy cycle must not disturb the older op
    @(negedge clk);
    mdu.mdu_op = MDU_MULT; mdu.rs = 32'd5; mdu.rt = 32'd6; mdu.start = 1'b1;
    @(negedge clk);
    drive_idle();
    n = 0;
    while (mdu.busy === 1'b1 && n < 200) begin
      n++;
      mdu.req = (n == 3);
      @(negedge clk);
    end
    mdu.req = 1'b0;
    checks++;
    if (n !== N_MUL) begin failures++; $display("FAIL req_mid_busy got=%0d exp=%0d", n, N_MUL); end
    read_hilo(h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'd30) begin
      failures++; $display("FAIL req_mid_commit got=%h_%h exp=00000000_0000001e", h, l);
    end
    m_hi = 32'd0;
    m_lo = 32'd30;
  endtask

  task automatic test_start_while_busy();
    int n;
    logic [31:0] h, l;
    @(negedge clk);
    mdu.mdu_op = MDU_DIV; mdu.rs = 32'd100; mdu.rt = 32'd7; mdu.start = 1'b1;
    @(negedge clk);
    drive_idle();
    n = 0;
    while (mdu.busy === 1'b1 && n < 200) begin
      n++;
      drive_idle();
      if (n == 2) begin
        mdu.mdu_op = MDU_MULT; mdu.rs = 32'd3; mdu.rt = 32'd4; mdu.start = 1'b1;
      end else if (n == 4) begin
        mdu.mdu_op = MDU_MTLO; mdu.rs = 32'h0000_AAAA;
      end
      @(negedge clk);
    end
    drive_idle();
    checks++;
    if (n !== N_DIV) begin failures++; $display("FAIL busy_restart_cycles got=%0d exp=%0d", n, N_DIV); end
    read_hilo(h, l);
    checks++;
    if (h !== 32'd2 || l !== 32'd14) begin
      failures++; $display("FAIL busy_restart_result got=%h_%h exp=00000002_0000000e", h, l);
    end
    m_hi = 32'd2;
    m_lo = 32'd14;
  endtask

  task automatic test_madd_encoding();
    int n;
    logic [31:0] h, l;
    issue(4'd9, 32'd3, 32'd4, 1'b1, 1'b0);
    count_busy(n);
    read_hilo(h, l);
`ifdef MDU_MADD_EN
    checks++;
    if (n !== N_MUL) begin failures++; $display("FAIL madd_busy got=%0d exp=%0d", n, N_MUL); end
    m_lo = m_lo + 32'd12;
`else
    checks++;
    if (n !== 0) begin failures++; $display("FAIL madd_off_busy got=%0d exp=0", n); end
`endif
    checks++;
    if (h !== m_hi || l !== m_lo) begin
      failures++; $display("FAIL madd_encoding_hilo got=%h_%h exp=%h_%h", h, l, m_hi, m_lo);
    end
  endtask

  task automatic test_random();
    int n, exp_n, sel;
    logic [3:0] op;
    logic [31:0] a, b, h, l;
    logic [64:0] r;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 9);
        2:       b = 32'd0 - $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      case (sel)
        0: op = MDU_MULT;
        1: op = MDU_MULTU;
        2: op = MDU_DIV;
        3: op = MDU_DIVU;
        4: op = MDU_MTHI;
        default: op = MDU_MTLO;
      endcase
      if (op == MDU_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      if (sel < 4) begin
        exp_n = (sel < 2) ? N_MUL : N_DIV;
        r = ref_result(op, a, b);
        run_op(op, a, b, n, h, l);
        checks++;
        if (n !== exp_n) begin failures++; $display("FAIL rand_busy[%0d] op=%0d got=%0d exp=%0d", i, op, n, exp_n); end
        m_hi = r[63:32];
        m_lo = r[31:0];
      end else begin
        issue(op, a, b, 1'b0, 1'b0);
        if (op == MDU_MTHI) m_hi = a;
        else m_lo = a;
        read_hilo(h, l);
      end
      exp_q.push_back(m_hi);
      exp_q.push_back(m_lo);
      checks++;
      if (h !== exp_q[0] || l !== exp_q[1]) begin
        failures++;
        $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, h, l, exp_q[0], exp_q[1]);
      end
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] h, l;
    issue(MDU_MTHI, 32'h1111_1111, 32'd0, 1'b0, 1'b0);
    issue(MDU_MTLO, 32'h2222_2222, 32'd0, 1'b0, 1'b0);
    issue(MDU_DIV, 32'd1000, 32'd3, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mdu.busy !== 1'b0 || mdu.state !== ST_IDLE) begin
      failures++; $display("FAIL rst_mid_busy got=%b/%0d exp=0/%0d", mdu.busy, mdu.state, ST_IDLE);
    end
    mdu.mdu_op = MDU_MFHI;
    #1 h = mdu.out;
    mdu.mdu_op = MDU_MFLO;
    #1 l = mdu.out;
    mdu.mdu_op = MDU_NONE;
    checks++;
    if (h !== 32'd0 || l !== 32'd0) begin failures++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", h, l); end
    @(negedge clk);
    reset = 1'b1;
    repeat (N_DIV + 5) @(negedge clk);
    checks++;
    if (mdu.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_late_busy got=%b exp=0", mdu.busy); end
    read_hilo(h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'd0) begin failures++; $display("FAIL rst_mid_no_commit got=%h_%h exp=0_0", h, l); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_req();
    test_start_while_busy();
    test_madd_encoding();
    test_random();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
